// File: rtl/dtree_stream_driver.sv
// Streams feature samples into a combinational decision tree, holds each one for SETTLE
// cycles, then captures the class. Optional per-class result counters: DTREE_CLASS_COUNT_EN.
module dtree_stream_driver #(
    parameter int DATA_W  = 8,
    parameter int CLASS_W = 2,
    parameter int SETTLE  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic [DATA_W-1:0]  feat_out,
    input  logic [CLASS_W-1:0] class_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
`ifdef DTREE_CLASS_COUNT_EN
    input  logic               cnt_clr,
    input  logic [CLASS_W-1:0] cnt_sel,
    output logic [15:0]        cnt_val,
`endif
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_OUT
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_t     state;
    logic [7:0] settle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            feat_out   <= '0;
            out_class  <= '0;
            out_valid  <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                // accept stage: feature is latched onto the tree input
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        feat_out   <= in_data;
                        settle_cnt <= SETTLE_LOAD;
                        in_ready   <= 1'b0;
                        state      <= ST_SETTLE;
                    end
                end
                // settle stage: tree output sampled once the count reaches zero
                ST_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        out_class <= class_in;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                // output stage: result held until the downstream takes it
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef DTREE_CLASS_COUNT_EN
    localparam int NUM_CLASS = 1 << CLASS_W;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] class_cnt [NUM_CLASS];
    logic        out_hs;

    assign out_hs = (state == ST_OUT) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASS; i++) class_cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_CLASS; i++) class_cnt[i] <= '0;
        end else if (out_hs) begin
            class_cnt[out_class] <= sat_inc(class_cnt[out_class]);
        end
    end

    assign cnt_val = class_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_dtree_stream_driver.sv
// Bench for dtree_stream_driver: scoreboard of accepted samples against a small tree model,
// directed handshake/backpressure/reset/stream scenarios plus a randomized phase.
`timescale 1ns/1ps
module tb_dtree_stream_driver;
    localparam int DATA_W  = 8;
    localparam int CLASS_W = 2;
    localparam int SETTLE  = 4;

    typedef struct {
        logic [7:0] data;
        logic [1:0] cls;
        int         acc_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic [7:0] feat_out;
    logic [1:0] class_in;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_class;
    logic       busy;
`ifdef DTREE_CLASS_COUNT_EN
    logic        cnt_clr = 1'b0;
    logic [1:0]  cnt_sel = 2'd1;
    logic [15:0] cnt_val;
`endif

    logic       force_en = 1'b0;
    logic [1:0] force_val = 2'd0;
    logic [1:0] noise = 2'd0;
    bit         pend_accept = 1'b0;
    bit         spacing_on = 1'b0;
    bit         seen = 1'b0;
    bit         have_last = 1'b0;
    logic [1:0] held_cls;
    int         last_res;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         k_acc;
    int         guard;
    bit         acc;
    exp_t       push_e;
    exp_t       pop_e;
    exp_t       sb [$];
    logic [7:0] stream_vals [4];

    dtree_stream_driver #(.DATA_W(DATA_W), .CLASS_W(CLASS_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .feat_out(feat_out), .class_in(class_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
`ifdef DTREE_CLASS_COUNT_EN
        .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_val(cnt_val),
`endif
        .busy(busy)
    );

    // Reference tree: class is a fixed bit-mix of the feature.
    function automatic logic [1:0] tree(input logic [7:0] d);
        return d[7:6] ^ d[4:3] ^ {d[0], d[5]};
    endfunction

    assign class_in = (force_en ? force_val : tree(feat_out)) ^ noise;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send(input logic [7:0] d, input bit keep);
        bit got;
        got = 1'b0;
        step();
        in_data = d;
        in_valid = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk); #1;
            got = pend_accept;
        end
        check("accept_timeout", got, 1);
        step();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk); #1;
            ok = out_valid;
        end
        check("out_timeout", ok, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk); #1;
            ok = !busy && !out_valid && (sb.size() == 0);
        end
        check(name, ok, 1);
    endtask

    // Issue side: an accepted sample pushes its expected result.
    initial forever begin
        @(negedge clk);
        pend_accept = rst_n && in_valid && in_ready;
        if (pend_accept) begin
            push_e.data    = in_data;
            push_e.cls     = force_en ? force_val : tree(in_data);
            push_e.acc_cyc = cyc + 1;
            sb.push_back(push_e);
        end
    end

    // Tree output wanders while a result is being held downstream.
    initial forever begin
        @(negedge clk);
        noise = out_valid ? 2'($urandom) : 2'b0;
    end

    // Monitor: pops and compares whenever a new result is presented.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            seen = 1'b0;
            have_last = 1'b0;
        end else begin
            if (!spacing_on) have_last = 1'b0;
            if (out_valid) begin
                if (!seen) begin
                    check("result_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        pop_e = sb.pop_front();
                        check("out_class", out_class, pop_e.cls);
                        check("latency", cyc - pop_e.acc_cyc, SETTLE);
                        check("feat_out_held", feat_out, pop_e.data);
                    end
                    held_cls = out_class;
                    seen = 1'b1;
                    if (spacing_on) begin
                        if (have_last) check("spacing", cyc - last_res, SETTLE + 2);
                        last_res = cyc;
                        have_last = 1'b1;
                    end
                end else begin
                    check("out_class_hold", out_class, held_cls);
                    check("in_ready_in_out", in_ready, 0);
                end
                if (out_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stream_vals[0] = 8'd0;   stream_vals[1] = 8'd128;
        stream_vals[2] = 8'd255; stream_vals[3] = 8'd64;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_feat_out", feat_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_class", out_class, 0);
        check("rst_busy", busy, 0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready_pre", in_ready, 0);
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        // Single sample with a fixed class
        step();
        force_en = 1'b1; force_val = 2'd2; out_ready = 1'b1;
        send(8'd37, 1'b0);
        @(negedge clk);
        check("single_feat", feat_out, 37);
        check("single_busy", busy, 1);
        repeat (SETTLE + 1) @(posedge clk);
        @(negedge clk);
        check("single_in_ready", in_ready, 1);
        check("single_out_valid", out_valid, 0);

        // Backpressure while the tree output changes and a new sample is offered
        step();
        force_val = 2'd1; out_ready = 1'b0;
        send(8'h5A, 1'b0);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            step();
            in_valid = 1'b1; in_data = 8'hC3;
            @(negedge clk); #1;
            check("bp_class", out_class, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_feat", feat_out, 8'h5A);
            check("bp_valid", out_valid, 1);
        end
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);

        // Reset in the middle of settling
        step();
        force_en = 1'b0;
        send(8'h77, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_feat", feat_out, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rel_pre", in_ready, 0);
        @(negedge clk);
        check("abort_rel_ready", in_ready, 1);
        check("abort_rel_feat", feat_out, 0);
        for (int i = 0; i < SETTLE + 3; i++) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end

        // Back-to-back stream
        step();
        spacing_on = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(stream_vals[i], 1'b1);
        in_valid = 1'b0;
        wait_idle("stream_drain");
        spacing_on = 1'b0;

        // Randomized traffic and backpressure
        k_acc = 0; guard = 0;
        while (k_acc < 40 && guard < 20000) begin
            @(negedge clk); #1;
            acc = pend_accept;
            step();
            guard++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc) k_acc++;
            if (acc || !in_valid) begin
                in_valid = (k_acc < 40) && ($urandom_range(0, 2) != 0);
                in_data = 8'($urandom);
            end
        end
        check("rand_accepts", k_acc, 40);
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle("rand_drain");

`ifdef DTREE_CLASS_COUNT_EN
        // Clear beats a simultaneous increment
        step();
        force_en = 1'b1; force_val = 2'd1; cnt_sel = 2'd1; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_cleared", cnt_val, 0);
        send(8'h11, 1'b0);
        wait_idle("cnt_drain1");
        send(8'h22, 1'b0);
        wait_idle("cnt_drain2");
        check("cnt_two", cnt_val, 2);
        step();
        out_ready = 1'b0;
        send(8'h33, 1'b0);
        wait_out();
        step();
        out_ready = 1'b1; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_clr_wins", cnt_val, 0);
        wait_idle("cnt_drain3");
        force_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
